pipe_share_arbiter: RTL and testbench
=====================================

Name: pipe_share_arbiter

Overview:
Controller that shares the two-stage pipeline register datapath (P1/P0 stages feeding output register R0) between two requesters. It arbitrates requests round-robin and sequences the datapath control strobes LD_P1_P0, Clr_P1_P0 and LD_R0. It tracks which requester owns the word in flight, counts delivered words and flags consumer stalls. It sits between the requester interfaces and the pipeline register datapath; the consumer acknowledges R0 loads with Ld.

Parameters:
CNT_W, 8, width of delivered-word counter out_cnt
WAIT_MAX, 16, consecutive S_WAIT cycles with Ld low that set stall_err (legal range 1..255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low (asserted at 0)
req  input  2  request from requester 0 and requester 1, level, held until granted
Ld  input  1  consumer ready: R0 may be loaded this cycle
gnt  output  2  one-hot grant pulse, 1 cycle, coincident with LD_P1_P0
LD_P1_P0  output  1  load P1/P0 stages with granted requester's word
Clr_P1_P0  output  1  clear P1/P0 stages
LD_R0  output  1  load R0 from P0
r0_tag  output  1  requester index of the word currently in R0
out_cnt  output  CNT_W  number of words delivered to R0, wraps
busy  output  1  high when state != S_IDLE
stall_err  output  1  sticky consumer-stall flag

Behaviour:
- Reset (rst=0, async): state=S_IDLE, last=1, tag_p=0, r0_tag=0, out_cnt=0, wait_cnt=0, stall_err=0; all combinational outputs decode to 0. Any in-flight word is dropped.
- States (2-bit): S_IDLE=00, S_1=01, S_FULL=10, S_WAIT=11.
- drain = (state==S_FULL or S_WAIT) and Ld.
- accept = |req and (state==S_IDLE or drain).
- pick: if only one req bit is set, grant that requester. If both are set, grant index ~last.
- Combinational outputs from current state and inputs, default 0:
  - LD_P1_P0 = accept; gnt = accept ? one-hot(pick) : 00.
  - LD_R0 = drain; Clr_P1_P0 = drain and ~|req.
- Transitions:
  - S_IDLE: accept -> S_1, else stay.
  - S_1: -> S_FULL unconditionally. req is ignored and gnt=00.
  - S_FULL: Ld and |req -> S_1; Ld and ~|req -> S_IDLE; ~Ld -> S_WAIT.
  - S_WAIT: same as S_FULL, except ~Ld stays in S_WAIT.
- Simultaneous drain and accept in S_FULL/S_WAIT: LD_R0 and LD_P1_P0 assert in the same cycle (back-to-back). Clr_P1_P0 stays 0.
- Registers, on the rising edge:
  - accept: last<=pick, tag_p<=pick.
  - drain: r0_tag<=tag_p, out_cnt<=out_cnt+1 (modulo 2^CNT_W, all-ones wraps to 0).
- Latency: grant to LD_R0 is a minimum of 2 cycles (grant in S_IDLE at cycle t, S_1 at t+1, earliest drain at t+2). Sustained throughput is one word per 2 cycles.
- Stall monitor:
  - wait_cnt (8 bit) increments each cycle with state==S_WAIT and Ld=0, saturating at WAIT_MAX. It clears to 0 in any other cycle.
  - stall_err is set on the edge where wait_cnt becomes WAIT_MAX and stays set until reset.
- Requests that are not granted are not queued by this block; the requester must hold req.
- Illegal state encodings are unreachable; the default branch goes to S_IDLE with outputs 0.

Test Plan:
- Reset, req=01, Ld=1: cycle0 gnt=01 and LD_P1_P0=1; cycle1 S_1 with all strobes 0; cycle2 LD_R0=1 and Clr_P1_P0=1 (req dropped); then r0_tag=0, out_cnt=1, busy=0.
- req=11 held, Ld=1: grants alternate 01,10,01,10 on cycles 0,2,4,6 (first grant 01 after reset). LD_R0 and LD_P1_P0 are coincident on cycles 2,4,6. r0_tag sequence 0,1,0.
- req=10 once, Ld=0 for 5 cycles then 1: S_FULL -> S_WAIT for 5 cycles, LD_R0 only on the cycle Ld rises, r0_tag=1, stall_err stays 0 (WAIT_MAX=16).
- Ld=0 held 20 cycles in S_WAIT: stall_err rises after the 16th S_WAIT cycle. It stays 1 after Ld=1 and the word drains, and clears only on rst=0.
- CNT_W=2, 5 words delivered: out_cnt sequence 1,2,3,0,1.
- Assert rst=0 mid-cycle while in S_WAIT: outputs drop to 0 immediately without a clock edge and state=S_IDLE. After release, a new req=01 is granted in S_IDLE.

Source files
------------

// File: rtl/pipe_share_arbiter.sv
// Round-robin owner of the shared P1/P0 -> R0 pipeline: sequences load/clear strobes,
// tracks which requester owns each word, counts deliveries and watches for consumer stalls.
module pipe_share_arbiter #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WAIT_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic             Ld,
    output logic [1:0]       gnt,
    output logic             LD_P1_P0,
    output logic             Clr_P1_P0,
    output logic             LD_R0,
    output logic             r0_tag,
    output logic [CNT_W-1:0] out_cnt,
    output logic             busy,
    output logic             stall_err
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        St1    = 2'b01,
        StFull = 2'b10,
        StWait = 2'b11
    } state_e;

    localparam logic [7:0] WaitMax = 8'(WAIT_MAX);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             tag_p_q, tag_p_d;
    logic             r0_tag_q, r0_tag_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             stall_err_q, stall_err_d;

    logic accept;
    logic drain;
    logic pick;
    logic wait_inc;

    // Both requesting: alternate away from the previous winner.
    always_comb begin
        unique case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last_q;
            default: pick = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        drain   = 1'b0;
        case (state_q)
            StIdle: begin
                accept = |req;
                if (accept) begin
                    state_d = St1;
                end
            end
            St1: begin
                state_d = StFull;
            end
            StFull, StWait: begin
                drain  = Ld;
                accept = Ld & (|req);
                if (Ld) begin
                    state_d = (|req) ? St1 : StIdle;
                end else begin
                    state_d = StWait;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Strobes must fall the instant reset asserts, not at the next edge.
        if (!rst) begin
            accept = 1'b0;
            drain  = 1'b0;
        end
    end

    always_comb begin
        LD_P1_P0  = accept;
        gnt       = accept ? (pick ? 2'b10 : 2'b01) : 2'b00;
        LD_R0     = drain;
        Clr_P1_P0 = drain & ~(|req);
        busy      = (state_q != StIdle);
        r0_tag    = r0_tag_q;
        out_cnt   = out_cnt_q;
        stall_err = stall_err_q;
    end

    always_comb begin
        last_d      = last_q;
        tag_p_d     = tag_p_q;
        r0_tag_d    = r0_tag_q;
        out_cnt_d   = out_cnt_q;
        wait_cnt_d  = 8'd0;
        stall_err_d = stall_err_q;
        wait_inc    = (state_q == StWait) & ~Ld;
        if (accept) begin
            last_d  = pick;
            tag_p_d = pick;
        end
        if (drain) begin
            r0_tag_d  = tag_p_q;
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end
        if (wait_inc) begin
            wait_cnt_d = (wait_cnt_q >= WaitMax) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d == WaitMax) begin
                stall_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            tag_p_q     <= 1'b0;
            r0_tag_q    <= 1'b0;
            out_cnt_q   <= '0;
            wait_cnt_q  <= 8'd0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            tag_p_q     <= tag_p_d;
            r0_tag_q    <= r0_tag_d;
            out_cnt_q   <= out_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_err_q <= stall_err_d;
        end
    end

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Bench for pipe_share_arbiter: directed scenarios then random traffic, every cycle compared
// against a word-age model of the shared pipeline.
module tb_pipe_share_arbiter;

    localparam int CNT_W    = 2;
    localparam int WAIT_MAX = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req;
    logic             ld;
    logic [1:0]       gnt;
    logic             ld_p1_p0;
    logic             clr_p1_p0;
    logic             ld_r0;
    logic             r0_tag;
    logic [CNT_W-1:0] out_cnt;
    logic             busy;
    logic             stall_err;

    int checks = 0;
    int errors = 0;

    // Model: at most one word in flight, aged in cycles since its grant.
    bit m_have;
    int m_age;
    bit m_tag;
    bit m_last;
    bit m_r0;
    int m_cnt;
    int m_wait;
    bit m_stall;

    pipe_share_arbiter #(
        .CNT_W   (CNT_W),
        .WAIT_MAX(WAIT_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .Ld       (ld),
        .gnt      (gnt),
        .LD_P1_P0 (ld_p1_p0),
        .Clr_P1_P0(clr_p1_p0),
        .LD_R0    (ld_r0),
        .r0_tag   (r0_tag),
        .out_cnt  (out_cnt),
        .busy     (busy),
        .stall_err(stall_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have  = 1'b0;
        m_age   = 0;
        m_tag   = 1'b0;
        m_last  = 1'b1;
        m_r0    = 1'b0;
        m_cnt   = 0;
        m_wait  = 0;
        m_stall = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ld_p1_p0", 32'(ld_p1_p0), 32'd0);
        chk("rst_clr", 32'(clr_p1_p0), 32'd0);
        chk("rst_ld_r0", 32'(ld_r0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_r0_tag", 32'(r0_tag), 32'd0);
        chk("rst_out_cnt", 32'(out_cnt), 32'd0);
        chk("rst_stall", 32'(stall_err), 32'd0);
    endtask

    task automatic step(input logic [1:0] r, input logic l);
        bit         drain_e;
        bit         accept_e;
        bit         pick;
        logic [1:0] egnt;
        @(negedge clk);
        req = r;
        ld  = l;
        #1;
        drain_e  = m_have && (m_age >= 2) && l;
        accept_e = (r != 2'b00) && (!m_have || drain_e);
        pick     = (r == 2'b11) ? !m_last : r[1];
        egnt     = accept_e ? (pick ? 2'b10 : 2'b01) : 2'b00;
        chk("gnt", 32'(gnt), 32'(egnt));
        chk("ld_p1_p0", 32'(ld_p1_p0), 32'(accept_e));
        chk("ld_r0", 32'(ld_r0), 32'(drain_e));
        chk("clr_p1_p0", 32'(clr_p1_p0), 32'(drain_e && (r == 2'b00)));
        chk("busy", 32'(busy), 32'(m_have));
        chk("r0_tag", 32'(r0_tag), 32'(m_r0));
        chk("out_cnt", 32'(out_cnt), 32'(m_cnt));
        chk("stall_err", 32'(stall_err), 32'(m_stall));
        @(posedge clk);
        // A word of age >= 3 has passed its first drain opportunity: consumer is stalling.
        if (m_have && (m_age >= 3) && !l) begin
            if (m_wait < WAIT_MAX) m_wait++;
            if (m_wait == WAIT_MAX) m_stall = 1'b1;
        end else begin
            m_wait = 0;
        end
        if (drain_e) begin
            m_r0   = m_tag;
            m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            m_have = 1'b0;
        end
        if (accept_e) begin
            m_have = 1'b1;
            m_tag  = pick;
            m_last = pick;
            m_age  = 1;
        end else if (m_have) begin
            m_age++;
        end
    endtask

    task automatic mid_cycle_reset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        model_reset();
        req = 2'b00;
        ld  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req = 2'b00;
        ld  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst = 1'b1;

        // Single word from requester 0 with a ready consumer.
        step(2'b01, 1'b1);
        repeat (3) step(2'b00, 1'b1);

        // Both requesting: alternating grants, back-to-back drain and load.
        repeat (8) step(2'b11, 1'b1);
        repeat (3) step(2'b00, 1'b1);

        // Short consumer stall, below the stall threshold.
        step(2'b10, 1'b0);
        repeat (6) step(2'b00, 1'b0);
        repeat (2) step(2'b00, 1'b1);

        // Long stall sets the sticky flag, which survives the drain.
        step(2'b01, 1'b1);
        repeat (22) step(2'b00, 1'b0);
        repeat (4) step(2'b00, 1'b1);

        // Reset asserted mid-cycle while waiting, then a fresh grant.
        step(2'b01, 1'b1);
        repeat (4) step(2'b01, 1'b0);
        mid_cycle_reset();
        step(2'b01, 1'b1);
        repeat (3) step(2'b00, 1'b1);

        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 75) begin
                for (int j = 0; j < 20; j++) step(2'($urandom), 1'b0);
            end
            if (i % 200 == 199) mid_cycle_reset();
            step(2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
